// File: rtl/dense_result_reader_pkg.sv
// Shared types and requantization helper for dense-layer result handling.
// Widths here are the default build widths (WIDTH=8, NEURON_NB=32).
package dense_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    localparam int WIDTH_DEF     = 8;
    localparam int NEURON_NB_DEF = 32;
    localparam int ACC_W         = 4 * WIDTH_DEF;
    localparam int OUT_W         = 2 * WIDTH_DEF;
    localparam int IDX_W         = (NEURON_NB_DEF > 1) ? $clog2(NEURON_NB_DEF) : 1;

    // Floor shift, optional ReLU, then saturate into OUT_W signed.
    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input int unsigned             shift,
        input bit                      relu
    );
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] maxv;
        logic signed [ACC_W-1:0] minv;
        maxv = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        minv = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        s = acc >>> shift;
        if (relu && s[ACC_W-1]) s = '0;
        if (s > maxv)      return maxv[OUT_W-1:0];
        else if (s < minv) return minv[OUT_W-1:0];
        else               return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/dense_result_reader_if.sv
// Layer-result input, streamed requantized output and status of the reader.
// slave = reader side, master = layer/downstream side.
interface dense_result_reader_if #(
    parameter int NEURON_NB = 32,
    parameter int WIDTH     = 8
);
    localparam int IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;

    logic signed [4*WIDTH-1:0] neuron_in [NEURON_NB];
    logic                      layer_done;
    logic signed [2*WIDTH-1:0] out_data;
    logic [IDX_W-1:0]          out_index;
    logic                      out_valid;
    logic                      out_last;
    logic                      out_ready;
    logic [IDX_W-1:0]          argmax_idx;
    logic                      argmax_valid;
    logic                      busy;
    logic                      overrun;

    modport slave (
        input  neuron_in, layer_done, out_ready,
        output out_data, out_index, out_valid, out_last,
               argmax_idx, argmax_valid, busy, overrun
    );

    modport master (
        output neuron_in, layer_done, out_ready,
        input  out_data, out_index, out_valid, out_last,
               argmax_idx, argmax_valid, busy, overrun
    );
endinterface

// File: rtl/dense_result_reader_requant_sat.sv
// Combinational requantizer: floor shift right, optional ReLU, saturate.
// Zero latency; no handshake of its own.
module requant_sat #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int RELU  = 1
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic signed [OUT_W-1:0] q
);
    localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] s;

    always_comb begin
        s = acc >>> SHIFT;
        if (RELU != 0 && s[IN_W-1]) s = '0;
        if (s > MAXV)      q = MAXV[OUT_W-1:0];
        else if (s < MINV) q = MINV[OUT_W-1:0];
        else               q = s[OUT_W-1:0];
    end
endmodule

// File: rtl/dense_result_reader.sv
// Snapshots the dense-layer result vector on each layer_done rise, streams requantized
// results one per valid/ready beat and reports the raw-value argmax after the last beat.
module dense_result_reader
    import dense_pkg::*;
#(
    parameter int NEURON_NB = 32,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 8,
    parameter int RELU      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dense_result_reader_if.slave  bus
);
    localparam int A_W = 4 * WIDTH;
    localparam int I_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
    localparam logic [I_W-1:0] LAST_IDX = I_W'(NEURON_NB - 1);

    state_t                state, state_nxt;
    logic                  done_q;
    logic                  start_ev;
    logic                  do_capture;
    logic                  do_load;
    logic                  beat;
    logic signed [A_W-1:0] buffer [NEURON_NB];
    logic [I_W-1:0]        index;
    logic [I_W-1:0]        idx_nxt;
    logic signed [A_W-1:0] best;
    logic [I_W-1:0]        best_idx;
    logic                  out_valid_q;
    logic [I_W-1:0]        argmax_idx_q;
    logic                  argmax_valid_q;
    logic                  overrun_q;

    assign start_ev = bus.layer_done & ~done_q;
    assign beat     = out_valid_q & bus.out_ready;
    assign idx_nxt  = index + I_W'(1);

    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_load    = 1'b0;
        case (state)
            IDLE: if (start_ev) begin
                do_capture = 1'b1;
                state_nxt  = LOAD;
            end
            LOAD: begin
                do_load   = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: if (beat && index == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A completion edge seen outside IDLE is dropped, not queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= bus.layer_done;
            if (start_ev && state != IDLE) overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NEURON_NB; i++) buffer[i] <= '0;
        end else if (do_capture) begin
            for (int i = 0; i < NEURON_NB; i++) buffer[i] <= bus.neuron_in[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index          <= '0;
            best           <= '0;
            best_idx       <= '0;
            out_valid_q    <= 1'b0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            if (do_capture) argmax_valid_q <= 1'b0;
            if (do_load) begin
                index       <= '0;
                best        <= buffer[0];
                best_idx    <= '0;
                out_valid_q <= 1'b1;
            end else if (beat) begin
                if (index == LAST_IDX) begin
                    out_valid_q    <= 1'b0;
                    argmax_idx_q   <= best_idx;
                    argmax_valid_q <= 1'b1;
                end else begin
                    index <= idx_nxt;
                    // Strict compare keeps the lowest index on ties.
                    if (buffer[idx_nxt] > best) begin
                        best     <= buffer[idx_nxt];
                        best_idx <= idx_nxt;
                    end
                end
            end
        end
    end

    requant_sat #(
        .IN_W  (A_W),
        .OUT_W (2 * WIDTH),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .acc (buffer[index]),
        .q   (bus.out_data)
    );

    assign bus.out_index    = index;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_valid_q && (index == LAST_IDX);
    assign bus.argmax_idx   = argmax_idx_q;
    assign bus.argmax_valid = argmax_valid_q;
    assign bus.busy         = (state != IDLE);
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_dense_result_reader.sv
// Directed + randomized bench for dense_result_reader, two instances (RELU=1 and RELU=0)
// sharing one stimulus, checked against an arithmetic reference model.
module tb_dense_result_reader;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   passed = 0;
    int   total  = 0;
    logic signed [31:0] vin [N];

    always #5 clk = ~clk;

    dense_result_reader_if #(.NEURON_NB(N), .WIDTH(8)) ifr ();
    dense_result_reader_if #(.NEURON_NB(N), .WIDTH(8)) if0 ();

    dense_result_reader #(.NEURON_NB(N), .WIDTH(8), .SHIFT(8), .RELU(1)) u_dut_relu (
        .clk(clk), .reset_n(reset_n), .bus(ifr));
    dense_result_reader #(.NEURON_NB(N), .WIDTH(8), .SHIFT(8), .RELU(0)) u_dut_lin (
        .clk(clk), .reset_n(reset_n), .bus(if0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Divide by 2^8 rounding toward -inf, then clamp.
    function automatic logic signed [15:0] ref_q(input logic signed [31:0] a, input bit relu);
        longint v, q;
        v = a;
        q = v / 256;
        if (v < 0 && (v % 256) != 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    function automatic int ref_argmax();
        int b = 0;
        for (int i = 1; i < N; i++) if (vin[i] > vin[b]) b = i;
        return b;
    endfunction

    task automatic set_in();
        for (int i = 0; i < N; i++) begin
            ifr.neuron_in[i] = vin[i];
            if0.neuron_in[i] = vin[i];
        end
    endtask

    task automatic scramble_in();
        for (int i = 0; i < N; i++) begin
            ifr.neuron_in[i] = $urandom;
            if0.neuron_in[i] = ifr.neuron_in[i];
        end
    endtask

    task automatic set_ld(input logic b);
        ifr.layer_done = b;
        if0.layer_done = b;
    endtask

    task automatic set_rdy(input logic b);
        ifr.out_ready = b;
        if0.out_ready = b;
    endtask

    task automatic capture(input bit drop);
        if (drop) begin
            set_ld(1'b0);
            @(posedge clk); #1;
        end
        set_in();
        set_ld(1'b1);
        @(posedge clk); #1;
        chk("load_busy", ifr.busy, 1);
        chk("load_valid", ifr.out_valid, 0);
        chk("load_amv_clear", ifr.argmax_valid, 0);
        scramble_in();
        @(posedge clk); #1;
    endtask

    // mode 0: ready high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic stream(input int mode, input int ovr_at, input int stop_beat);
        int   beat = 0;
        int   cyc = 0;
        logic rdy;
        while (beat < stop_beat && cyc < 80) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            set_rdy(rdy);
            if (cyc == ovr_at) set_ld(1'b0);
            if (cyc == ovr_at + 1) set_ld(1'b1);
            chk("beat_valid", ifr.out_valid, 1);
            chk("beat_index", ifr.out_index, beat);
            chk("beat_last", ifr.out_last, (beat == N - 1));
            chk("beat_data_relu", ifr.out_data, ref_q(vin[beat], 1'b1));
            chk("beat_data_lin", if0.out_data, ref_q(vin[beat], 1'b0));
            if (rdy) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("beat_count", beat, stop_beat);
    endtask

    task automatic finish_chk();
        chk("end_valid", ifr.out_valid, 0);
        chk("end_last", ifr.out_last, 0);
        chk("end_busy", ifr.busy, 0);
        chk("argmax_valid", ifr.argmax_valid, 1);
        chk("argmax_idx", ifr.argmax_idx, ref_argmax());
        chk("argmax_idx_lin", if0.argmax_idx, ref_argmax());
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) vin[i] = '0;
        set_in();
        set_ld(1'b0);
        set_rdy(1'b0);
        #3;
        chk("rst_valid", ifr.out_valid, 0);
        chk("rst_last", ifr.out_last, 0);
        chk("rst_data", ifr.out_data, 0);
        chk("rst_index", ifr.out_index, 0);
        chk("rst_amv", ifr.argmax_valid, 0);
        chk("rst_busy", ifr.busy, 0);
        chk("rst_overrun", ifr.overrun, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", ifr.busy, 0);

        // Basic stream
        vin[0] = 32'h1234; vin[1] = 32'h0100; vin[2] = 32'h7F00; vin[3] = 32'h0050;
        capture(1'b1);
        stream(0, -1, N);
        finish_chk();
        chk("t1_data0", ref_q(vin[0], 1'b1), 16'h0012);

        // Saturation / sign, random ready
        vin[0] = 32'h0100_0000; vin[1] = -300; vin[2] = 32'h8000_0000; vin[3] = 0;
        capture(1'b1);
        stream(2, -1, N);
        finish_chk();

        // Backpressure pattern
        for (int i = 0; i < N; i++) vin[i] = $urandom;
        capture(1'b1);
        stream(1, -1, N);
        finish_chk();
        chk("pre_overrun", ifr.overrun, 0);

        // Tie plus overrun mid-stream
        vin[0] = 5; vin[1] = 9; vin[2] = 9; vin[3] = 1;
        capture(1'b1);
        stream(0, 0, N);
        finish_chk();
        chk("overrun_set", ifr.overrun, 1);
        chk("overrun_lin", if0.overrun, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_recapture", ifr.busy, 0);

        // Random vectors
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++)
                vin[i] = $urandom_range(0, 1) ? $urandom : (int'($urandom_range(0, 1000)) - 500) * 200;
            capture(1'b1);
            stream(2, -1, N);
            finish_chk();
        end

        // Asynchronous reset in the middle of beat 2
        for (int i = 0; i < N; i++) vin[i] = $urandom;
        capture(1'b1);
        stream(0, -1, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", ifr.out_valid, 0);
        chk("arst_busy", ifr.busy, 0);
        chk("arst_amv", ifr.argmax_valid, 0);
        chk("arst_overrun", ifr.overrun, 0);
        chk("arst_data", ifr.out_data, 0);
        for (int i = 0; i < N; i++) vin[i] = $urandom;
        set_in();
        @(negedge clk);
        reset_n = 1'b1;
        capture(1'b0);
        stream(2, -1, N);
        finish_chk();
        repeat (3) @(posedge clk);
        #1;
        chk("single_capture", ifr.busy, 0);
        chk("post_rst_overrun", ifr.overrun, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dense_result_reader.md
Name: dense_result_reader

Overview:
- Consumer end of the dense-layer output interface.
- Takes the full-parallel neuron result vector and the level-type layer-done flag, snapshots the vector once per completion, and requantizes each result from 4*WIDTH down to 2*WIDTH.
- Streams the results one per handshake on a valid/ready port, tracks the argmax, and reports it when the stream ends.
- Sits between a dense layer and the next layer's input loader or the classifier output.

Parameters:
- NEURON_NB, 32, number of neuron results in the vector.
- WIDTH, 8, base width. Inputs are 4*WIDTH signed; outputs are 2*WIDTH signed.
- SHIFT, 8, arithmetic right-shift applied during requantization (0..4*WIDTH-1).
- RELU, 1, when 1 negative requantized values are clamped to 0.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- neuron_in  in  signed 4*WIDTH x [0:NEURON_NB-1]  layer results.
- layer_done  in  1  level flag from the layer; stays high once its results are valid.
- out_data  out  signed 2*WIDTH  requantized result.
- out_index  out  $clog2(NEURON_NB)  neuron index of out_data.
- out_valid  out  1  out_data/out_index valid.
- out_last  out  1  high with the index NEURON_NB-1 beat.
- out_ready  in  1  downstream accepts the current beat.
- argmax_idx  out  $clog2(NEURON_NB)  index of the largest raw result.
- argmax_valid  out  1  argmax_idx valid.
- busy  out  1  high in LOAD or STREAM.
- overrun  out  1  sticky: a completion edge arrived while busy.

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0:
  - state=IDLE, done_q=0, snapshot buffer=0.
  - All outputs are 0: out_valid, out_last, out_data, out_index, argmax_idx, argmax_valid, busy, overrun.
- Edge detect:
  - done_q <= layer_done every cycle.
  - start_ev = layer_done & ~done_q.
  - A layer_done already high when reset releases produces exactly one start_ev.
- FSM states IDLE, LOAD, STREAM:
  - IDLE: on start_ev, capture all of neuron_in into the buffer, clear argmax_valid, go to LOAD.
  - LOAD: one cycle. Set index=0, best=buffer[0], best_idx=0, assert out_valid. Go to STREAM.
  - STREAM: a beat completes on an edge where out_valid & out_ready.
    - On completion with index<NEURON_NB-1: index+1; if buffer[index+1] > best, update best and best_idx.
    - On completion with index=NEURON_NB-1: out_valid<=0, argmax_idx<=best_idx, argmax_valid<=1, go to IDLE.
- Latency:
  - start_ev sampled at edge t → LOAD after t → out_valid high after edge t+1.
  - Minimum NEURON_NB+1 cycles from capture to argmax_valid with out_ready held high.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
  - out_valid never drops without a completed beat, except on reset.
  - out_ready while out_valid=0 is ignored.
- Requantization (combinational from buffer[index]):
  - Arithmetic shift right by SHIFT (floor toward -inf).
  - Then, if RELU, negative → 0.
  - Then saturate to [-2^(2*WIDTH-1), 2^(2*WIDTH-1)-1].
- Argmax:
  - Compares raw 4*WIDTH signed values, not requantized ones.
  - Strict greater-than, so a tie keeps the lowest index.
  - argmax_valid stays high until the next start_ev.
- Simultaneous events:
  - start_ev during LOAD/STREAM is ignored (no recapture) and sets overrun=1. overrun is cleared only by reset.
  - A last-beat completion and start_ev on the same edge: the state goes to IDLE, and the edge counts as overrun, not a new capture.
- neuron_in may change after capture without affecting the stream.
- NEURON_NB=1: LOAD → STREAM with out_last=1 on the first beat.

Decomposition:
- Package dense_pkg holds:
  - state enum {IDLE, LOAD, STREAM}
  - localparams ACC_W=4*WIDTH, OUT_W=2*WIDTH, IDX_W=$clog2(NEURON_NB)
  - function requant(acc, shift, relu) returning saturated OUT_W. This function is shared with future layers.
- One sub-module, requant_sat: a combinational shift/ReLU/saturate stage, unit-testable on its own.
- FSM, buffer and argmax stay in the top level.

Test Plan:
All scenarios use NEURON_NB=4, WIDTH=8, SHIFT=8.
1. Basic stream: RELU=1, out_ready=1, neuron_in={0x1234, 0x0100, 0x7F00, 0x0050}, raise layer_done at edge t.
   → out_valid from t+2; beats 0x0012, 0x0001, 0x007F, 0x0000 at indexes 0..3; out_last only on index 3; then argmax_idx=2, argmax_valid=1.
2. Saturation and sign with RELU=0: inputs {0x01000000, -300, -0x7FFFFFFF-1, 0}.
   → outputs 0x7FFF, 0xFFFE, 0x8000, 0x0000.
   Same inputs with RELU=1 → second and third outputs are 0.
3. Backpressure: out_ready toggles 1,0,0,1,….
   → out_data/out_index stable during every stall, no beat skipped or duplicated, exactly 4 beats.
4. Tie and overrun:
   - Inputs {5, 9, 9, 1} → argmax_idx=1.
   - Drop and re-raise layer_done mid-stream → overrun=1, the stream continues with the original snapshot.
5. Reset mid-stream: assert reset_n=0 asynchronously (between edges) during beat 2.
   → out_valid, busy and argmax_valid fall immediately.
   Release with layer_done held high → exactly one new capture and a full 4-beat stream.
